// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed-latency 64-bit reads with a byte-strobed load port.
// Define INST_MEM_LINEBUF_EN to add a one-entry line buffer that answers repeat fetches in one cycle.
module inst_mem_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [63:0] ld_data,
    input  logic [7:0]  ld_strb
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    // 65-bit limit so the upper bound cannot wrap for a range at the top of the address space
    localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'd8 << DEPTH_LOG2);

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic idx_t word_idx(input logic [63:0] a);
        return idx_t'((a - BASE_ADDR) >> 3);
    endfunction

    logic [1:0]  state;
    logic [3:0]  count;
    logic [63:0] addr_q;
    logic [63:0] mem [WORDS];

    logic [63:0] req_a;
    logic [63:0] ld_a;
    logic [63:0] rd_a;
    logic [63:0] rd_word;
    logic        rd_err;
    idx_t        rd_idx;
    idx_t        ld_idx;
    logic        capture;
    logic        lb_hit;
    logic [63:0] hit_data;

    assign req_a   = req_addr & ~64'h7;
    assign ld_a    = ld_addr & ~64'h7;
    // Direct IDLE->RESP captures from the live request; otherwise from the latched address
    assign rd_a    = (state == IDLE) ? req_a : addr_q;
    assign rd_err  = !in_range(rd_a);
    assign rd_idx  = word_idx(rd_a);
    assign rd_word = mem[rd_idx];
    assign ld_idx  = word_idx(ld_a);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

`ifdef INST_MEM_LINEBUF_EN
    logic        lb_valid;
    logic [63:0] lb_tag;
    logic [63:0] lb_data;
    logic        ld_on_lb;

    assign ld_on_lb = ld_en && (ld_a == lb_tag);
    // A load to the buffered word in the same cycle forces the normal path
    assign lb_hit   = lb_valid && !ld_on_lb && (req_a == lb_tag);
    assign hit_data = lb_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            lb_valid <= 1'b0;
            lb_tag   <= '0;
            lb_data  <= '0;
        end else if (capture && !rd_err) begin
            lb_valid <= !(ld_en && (ld_a == rd_a));
            lb_tag   <= rd_a;
            lb_data  <= rd_word;
        end else if (ld_on_lb) begin
            lb_valid <= 1'b0;
        end
    end
`else
    assign lb_hit   = 1'b0;
    assign hit_data = '0;
`endif

    assign capture = ((state == IDLE) && req_valid && !lb_hit && (LATENCY == 1))
                  || ((state == WAIT) && (count == 4'd0));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            addr_q    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (capture) begin
                resp_data <= rd_err ? '0 : rd_word;
                resp_err  <= rd_err;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_a;
                        if (lb_hit) begin
                            state     <= RESP;
                            resp_data <= hit_data;
                            resp_err  <= 1'b0;
                        end else if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) state <= RESP;
                    else               count <= count - 4'd1;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (ld_en && in_range(ld_a)) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (ld_strb[i]) mem[ld_idx][8*i +: 8] <= ld_data[8*i +: 8];
            end
        end
    end
endmodule
